// File: rtl/wm_pkg.sv
// Shared phase codes, default durations and timer state encoding for the
// washing-machine phase timer.
package wm_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd2;
    localparam logic [2:0] PH_HEAT  = 3'd3;
    localparam logic [2:0] PH_WASH  = 3'd4;
    localparam logic [2:0] PH_RINSE = 3'd5;
    localparam logic [2:0] PH_SPIN  = 3'd6;

    localparam int DEF_PRESCALE     = 1000;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_FILL_TIMEOUT = 120;
    localparam int DEF_HEAT_TIMEOUT = 300;
    localparam int DEF_WASH_TICKS   = 600;
    localparam int DEF_RINSE_TICKS  = 300;
    localparam int DEF_SPIN_TICKS   = 240;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } tmr_state_e;

    // op_vec = {spin, rinse, wash, heat, fill}; anything not one-hot is idle
    function automatic logic [2:0] decode_op(input logic [4:0] op_vec);
        logic [2:0] code;
        code = PH_IDLE;
        case (op_vec)
            5'b00001: code = PH_FILL;
            5'b00010: code = PH_HEAT;
            5'b00100: code = PH_WASH;
            5'b01000: code = PH_RINSE;
            5'b10000: code = PH_SPIN;
            default:  code = PH_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wm_prescaler.sv
// Divides enabled clock cycles down to a one-cycle timer tick every PRESCALE
// enabled cycles; clear restarts the count from zero.
module wm_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST  = W'(PRESCALE - 1);
    localparam logic [W-1:0] ONE_W = W'(1);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = enable && w_wrap;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + ONE_W;
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Measures each controller phase and raises timeout/completion levels once
// the phase's tick budget is used up.
//   state   | meaning
//   IDLE    | no operation requested, outputs low
//   RUN     | counting down the active phase's budget
//   EXPIRED | budget used up, remaining held at 0, level output high
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
    parameter int HEAT_TIMEOUT = DEF_HEAT_TIMEOUT,
    parameter int WASH_TICKS   = DEF_WASH_TICKS,
    parameter int RINSE_TICKS  = DEF_RINSE_TICKS,
    parameter int SPIN_TICKS   = DEF_SPIN_TICKS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fill_Water_Operation,
    input  logic             heat_Water_Operation,
    input  logic             wash_Operation,
    input  logic             rinse_Operation,
    input  logic             spin_Operation,
    input  logic             sig_Pause,
    output logic             sig_Time_Out,
    output logic             sig_Wash_Completed,
    output logic             sig_Rinse_Completed,
    output logic             sig_Spin_Completed,
    output logic             sig_Phase_Error,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    function automatic logic [CNT_W-1:0] phase_limit(input logic [2:0] ph);
        logic [CNT_W-1:0] lim;
        lim = '0;
        case (ph)
            PH_FILL:  lim = CNT_W'(FILL_TIMEOUT);
            PH_HEAT:  lim = CNT_W'(HEAT_TIMEOUT);
            PH_WASH:  lim = CNT_W'(WASH_TICKS);
            PH_RINSE: lim = CNT_W'(RINSE_TICKS);
            PH_SPIN:  lim = CNT_W'(SPIN_TICKS);
            default:  lim = '0;
        endcase
        return lim;
    endfunction

    logic [4:0]       w_op_vec;
    logic [2:0]       w_req;
    logic             w_multi;
    logic             w_tick;
    logic             w_entry;
    logic             w_pre_en;

    tmr_state_e       r_state, w_nxt_state;
    logic [2:0]       r_phase, w_nxt_phase;
    logic [CNT_W-1:0] r_rem, w_nxt_rem;
    logic             r_exp, w_nxt_exp;
    logic             r_err;

    assign w_op_vec = {spin_Operation, rinse_Operation, wash_Operation,
                       heat_Water_Operation, fill_Water_Operation};
    assign w_multi  = |(w_op_vec & (w_op_vec - 5'd1));
    assign w_req    = decode_op(w_op_vec);
    assign w_pre_en = (r_state == ST_RUN) && !sig_Pause;

    wm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (w_pre_en),
        .clear  (w_entry),
        .tick   (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_IDLE;
            r_rem   <= '0;
            r_exp   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            r_rem   <= w_nxt_rem;
            r_exp   <= w_nxt_exp;
            r_err   <= w_multi;
        end
    end

    // Entry and exit outrank any decrement on the same edge.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_rem   = r_rem;
        w_nxt_exp   = r_exp;
        w_entry     = 1'b0;
        if (w_req != PH_IDLE && w_req != r_phase) begin
            w_entry     = 1'b1;
            w_nxt_phase = w_req;
            w_nxt_rem   = phase_limit(w_req);
            w_nxt_exp   = 1'b0;
            w_nxt_state = ST_RUN;
        end else if (w_req == PH_IDLE) begin
            w_nxt_phase = PH_IDLE;
            w_nxt_rem   = '0;
            w_nxt_exp   = 1'b0;
            w_nxt_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_rem == '0) begin
                        w_nxt_exp   = 1'b1;
                        w_nxt_state = ST_EXPIRED;
                    end else if (w_tick) begin
                        w_nxt_rem = r_rem - ONE_C;
                        if (r_rem == ONE_C) begin
                            w_nxt_exp   = 1'b1;
                            w_nxt_state = ST_EXPIRED;
                        end
                    end
                end
                ST_IDLE, ST_EXPIRED: begin
                    w_nxt_state = r_state;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    assign sig_Time_Out        = r_exp && (r_phase == PH_FILL || r_phase == PH_HEAT);
    assign sig_Wash_Completed  = r_exp && (r_phase == PH_WASH);
    assign sig_Rinse_Completed = r_exp && (r_phase == PH_RINSE);
    assign sig_Spin_Completed  = r_exp && (r_phase == PH_SPIN);
    assign sig_Phase_Error     = r_err;
    assign phase               = r_phase;
    assign remaining           = r_rem;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed scenarios plus randomized phase sequences, all outputs checked
// every cycle against an elapsed-time model of the phase timer.
module tb_wm_phase_timer;

    localparam int P     = 4;
    localparam int CW    = 16;
    localparam int FILL  = 2;
    localparam int HEAT  = 300;
    localparam int WASH  = 3;
    localparam int RINSE = 0;
    localparam int SPIN  = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fill_op = 1'b0, heat_op = 1'b0, wash_op = 1'b0;
    logic          rinse_op = 1'b0, spin_op = 1'b0, pause = 1'b0;
    logic          time_out, wash_c, rinse_c, spin_c, err;
    logic [2:0]    phase;
    logic [CW-1:0] remaining;

    int tests = 0;
    int fails = 0;

    wm_phase_timer #(
        .PRESCALE     (P),
        .CNT_W        (CW),
        .FILL_TIMEOUT (FILL),
        .HEAT_TIMEOUT (HEAT),
        .WASH_TICKS   (WASH),
        .RINSE_TICKS  (RINSE),
        .SPIN_TICKS   (SPIN)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .fill_Water_Operation (fill_op),
        .heat_Water_Operation (heat_op),
        .wash_Operation       (wash_op),
        .rinse_Operation      (rinse_op),
        .spin_Operation       (spin_op),
        .sig_Pause            (pause),
        .sig_Time_Out         (time_out),
        .sig_Wash_Completed   (wash_c),
        .sig_Rinse_Completed  (rinse_c),
        .sig_Spin_Completed   (spin_c),
        .sig_Phase_Error      (err),
        .phase                (phase),
        .remaining            (remaining)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_op(input logic [4:0] v);
        {spin_op, rinse_op, wash_op, heat_op, fill_op} = v;
    endtask

    // ---------------- behavioural model ----------------
    int m_phase = 0, m_limit = 0, m_run = 0, m_edges = 0;
    bit m_err = 0, m_valid = 0;

    function automatic int lim_of(input int ph);
        case (ph)
            2: return FILL;
            3: return HEAT;
            4: return WASH;
            5: return RINSE;
            6: return SPIN;
            default: return 0;
        endcase
    endfunction

    function automatic int req_of(input logic [4:0] op);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) if (op[i]) n++;
        if (n != 1) return 0;
        if (op[0]) return 2;
        if (op[1]) return 3;
        if (op[2]) return 4;
        if (op[3]) return 5;
        return 6;
    endfunction

    function automatic int exp_rem();
        int d;
        if (m_phase == 0) return 0;
        d = m_run / P;
        return (m_limit > d) ? m_limit - d : 0;
    endfunction

    function automatic bit exp_done();
        if (m_phase == 0) return 1'b0;
        if (m_limit == 0) return m_edges >= 1;
        return m_run >= m_limit * P;
    endfunction

    initial begin
        int  req;
        bit  d;
        forever begin
            @(posedge clock);
            req = req_of({spin_op, rinse_op, wash_op, heat_op, fill_op});
            if (reset) begin
                m_phase = 0; m_limit = 0; m_run = 0; m_edges = 0; m_err = 0;
                m_valid = 1;
            end else begin
                m_err = (int'(fill_op) + int'(heat_op) + int'(wash_op) +
                         int'(rinse_op) + int'(spin_op)) > 1;
                if (req != 0 && req != m_phase) begin
                    m_phase = req; m_limit = lim_of(req); m_run = 0; m_edges = 0;
                end else if (req == 0) begin
                    m_phase = 0; m_limit = 0; m_run = 0; m_edges = 0;
                end else begin
                    m_edges++;
                    if (!pause) m_run++;
                end
            end
            #1;
            if (m_valid) begin
                d = exp_done();
                check("phase", phase, m_phase);
                check("remaining", remaining, exp_rem());
                check("phase_error", err, m_err);
                check("time_out", time_out, d && (m_phase == 2 || m_phase == 3));
                check("wash_completed", wash_c, d && m_phase == 4);
                check("rinse_completed", rinse_c, d && m_phase == 5);
                check("spin_completed", spin_c, d && m_phase == 6);
            end
        end
    end

    // ---------------- stimulus and pinned expectations ----------------
    initial begin
        logic [4:0] v;
        int a, b, hold;

        // Reset with wash requested, then release: fresh load.
        reset = 1'b1;
        drive_op(5'b00100);
        repeat (2) @(negedge clock);
        check("rst_outputs", {time_out, wash_c, rinse_c, spin_c, err}, 0);
        check("rst_phase", phase, 0);
        check("rst_remaining", remaining, 0);
        reset = 1'b0;
        @(negedge clock);
        check("wash_load_rem", remaining, 3);
        check("wash_load_phase", phase, 4);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 11) check("wash_not_yet", wash_c, 0);
            if (k == 12) check("wash_done_12", wash_c, 1);
        end
        repeat (5) @(negedge clock);
        check("wash_hold", wash_c, 1);
        drive_op(5'b00000);
        @(negedge clock);
        check("wash_drop", wash_c, 0);
        check("wash_exit_phase", phase, 0);

        // Fill never released: timeout after 8 cycles, no underflow.
        drive_op(5'b00001);
        @(negedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 7) check("fill_not_yet", time_out, 0);
            if (k == 8) check("fill_timeout_8", time_out, 1);
        end
        repeat (20) @(negedge clock);
        check("fill_no_underflow", remaining, 0);
        check("fill_timeout_hold", time_out, 1);
        drive_op(5'b00000);
        @(negedge clock);

        // Fill then direct switch to heat.
        drive_op(5'b00001);
        repeat (3) @(negedge clock);
        check("fill_phase", phase, 2);
        drive_op(5'b00010);
        @(negedge clock);
        check("heat_phase", phase, 3);
        check("heat_reload", remaining, 300);
        check("heat_no_timeout", time_out, 0);
        repeat (10) @(negedge clock);
        check("heat_still_running", time_out, 0);
        drive_op(5'b00000);
        @(negedge clock);

        // Wash with pause over edges 5..9 after load.
        drive_op(5'b00100);
        @(negedge clock);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 4) begin
                check("pause_rem_before", remaining, 2);
                pause = 1'b1;
            end
            if (k == 9) begin
                check("pause_rem_frozen", remaining, 2);
                pause = 1'b0;
            end
            if (k == 16) check("pause_wash_not_yet", wash_c, 0);
            if (k == 17) check("pause_wash_done_17", wash_c, 1);
        end
        drive_op(5'b00000);
        @(negedge clock);

        // Zero-length rinse expires one edge after entry.
        drive_op(5'b01000);
        @(negedge clock);
        check("rinse_entry_phase", phase, 5);
        check("rinse_entry_done", rinse_c, 0);
        @(negedge clock);
        check("rinse_done", rinse_c, 1);
        drive_op(5'b00000);
        @(negedge clock);

        // Multi-hot request, then reset mid-wash.
        drive_op(5'b10100);
        @(negedge clock);
        check("multi_error", err, 1);
        check("multi_phase", phase, 0);
        check("multi_no_done", {wash_c, spin_c}, 0);
        drive_op(5'b00000);
        @(negedge clock);
        check("multi_error_clear", err, 0);
        drive_op(5'b00100);
        repeat (14) @(negedge clock);
        check("pre_reset_wash", wash_c, 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_outputs", {time_out, wash_c, rinse_c, spin_c, err}, 0);
        check("midrst_phase", phase, 0);
        check("midrst_remaining", remaining, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_reload", remaining, 3);

        // Randomized phase sequences.
        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, 99);
            if (a < 8) begin
                b = $urandom_range(0, 4);
                v = 5'b00001 << b;
                v = v | (5'b00001 << ((b + 1 + $urandom_range(0, 3)) % 5));
            end else if (a < 25) begin
                v = 5'b00000;
            end else begin
                v = 5'b00001 << $urandom_range(0, 4);
            end
            drive_op(v);
            hold = $urandom_range(1, 30);
            for (int c = 0; c < hold; c++) begin
                pause = ($urandom_range(0, 9) == 0);
                reset = ($urandom_range(0, 199) == 0);
                @(negedge clock);
            end
        end
        reset = 1'b0;
        pause = 1'b0;
        drive_op(5'b00000);
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
- Timing stage directly upstream of the washing-machine controller FSM.
- Watches the controller's one-hot operation outputs and measures the duration of each phase.
- Fill and heat phases: drives sig_Time_Out back to the controller.
- Wash, rinse and spin phases: drives the corresponding completion signal.
- Also exports the active phase code and remaining time for display and debug.

Parameters:
- PRESCALE, 1000: clock cycles per timer tick (minimum 1).
- CNT_W, 16: width of the remaining-ticks counter.
- FILL_TIMEOUT, 120: ticks allowed in fill before timeout.
- HEAT_TIMEOUT, 300: ticks allowed in heat before timeout.
- WASH_TICKS, 600: wash duration in ticks.
- RINSE_TICKS, 300: rinse duration in ticks.
- SPIN_TICKS, 240: spin duration in ticks.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fill_Water_Operation  in  1  controller is in the fill phase.
- heat_Water_Operation  in  1  controller is in the heat phase.
- wash_Operation  in  1  controller is in the wash phase.
- rinse_Operation  in  1  controller is in the rinse phase.
- spin_Operation  in  1  controller is in the spin phase.
- sig_Pause  in  1  freezes the prescaler and counter while high.
- sig_Time_Out  out  1  fill or heat limit expired.
- sig_Wash_Completed  out  1  wash duration elapsed.
- sig_Rinse_Completed  out  1  rinse duration elapsed.
- sig_Spin_Completed  out  1  spin duration elapsed.
- sig_Phase_Error  out  1  more than one operation input is high.
- phase  out  3  active phase code: 0 idle, 2 fill, 3 heat, 4 wash, 5 rinse, 6 spin.
- remaining  out  CNT_W  ticks left in the current phase.

Behaviour:
- Reset (synchronous, active-high):
  - phase=0, remaining=0, prescaler=0, expired flag=0.
  - All outputs are 0 on the first edge with reset high.
  - Reset mid-phase abandons the phase. After reset releases, an already-high operation input counts as a fresh entry and reloads.
- Input decode, done every cycle: the five operation inputs form op_vec.
  - Zero bits set: requested phase = idle.
  - Exactly one bit set: requested phase = that phase's code.
  - More than one bit set: requested phase = idle and sig_Phase_Error=1. The error is registered, so it appears 1 cycle after the condition.
- FSM states: IDLE, RUN, EXPIRED.
- Entry: on the edge where the requested phase is non-idle and differs from the registered phase:
  - phase <= requested code.
  - remaining <= that phase's limit (truncated to CNT_W).
  - prescaler <= 0, expired <= 0, state <= RUN.
  - This applies from any state, so a direct phase-to-phase change reloads with no idle gap.
- RUN:
  - Each cycle with sig_Pause=0 the prescaler increments.
  - When the prescaler reaches PRESCALE-1, it wraps to 0 and remaining decrements by 1.
  - On the edge where remaining becomes 0, expired <= 1 and state <= EXPIRED.
  - A limit of 0 sets expired on the first edge after entry.
- Latency: with PRESCALE=P and limit N≥1, expired is visible N*P cycles after the entry edge, given no pause.
- EXPIRED: remaining holds 0 and the counter stops (no underflow).
- Output drive (combinational from registered state only; no combinational path from inputs):
  - Fill or heat: sig_Time_Out=1.
  - Wash: sig_Wash_Completed=1.
  - Rinse: sig_Rinse_Completed=1.
  - Spin: sig_Spin_Completed=1.
  - These outputs are levels, held for as long as the phase stays active, so the controller's two-stage registered transition cannot miss them.
- Exit: when the requested phase becomes idle:
  - Next edge: phase <= 0, remaining <= 0, expired <= 0, state <= IDLE.
  - All completion and timeout outputs drop on that same edge.
- Pause:
  - Pause asserted on the same cycle as the wrap edge blocks the decrement.
  - Pause does not block entry reload or exit.
- Simultaneous events: exit or re-entry takes priority over a decrement on the same edge.

Decomposition:
- Shared package wm_pkg holds:
  - the 3-bit phase/state codes (0..7, matching the controller encoding);
  - the default phase durations;
  - the FSM state enum for IDLE, RUN, EXPIRED.
- One sub-module, wm_prescaler:
  - Inputs: clock, reset, enable, clear.
  - Output: a one-cycle tick every PRESCALE enabled cycles.
  - Instantiated once; its clear input is driven by phase entry.

Test Plan (PRESCALE=4, WASH_TICKS=3, FILL_TIMEOUT=2, RINSE_TICKS=0):
- Reset with wash_Operation high, then release → remaining=3 one edge after release; sig_Wash_Completed rises exactly 12 cycles after the load edge and holds until wash_Operation falls; it is 0 on the edge after the fall.
- fill_Water_Operation high, never changes → sig_Time_Out=1 after 8 cycles, remaining=0 stays 0 for 20 more cycles with no underflow.
- Fill for 3 cycles, then switch directly to heat → phase 2→3, remaining reloads to HEAT_TIMEOUT, sig_Time_Out remains 0.
- Wash with sig_Pause high for cycles 5–9 → completion delayed by exactly 5 cycles (17 after load); remaining frozen during pause.
- rinse_Operation high (RINSE_TICKS=0) → sig_Rinse_Completed=1 one edge after entry.
- wash_Operation and spin_Operation both high → sig_Phase_Error=1 next cycle, phase=0, no completion output; reset asserted mid-wash clears every output on that edge.
